// File: rtl/rv32imc_types.sv
// Shared core types: instruction-cache FSM state and refill request payload.
package rv32imc_types;

   // Instruction cache controller states.
   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      REQ,
      FILL,
      RESP
   } icache_state_t;

   // Backing-memory refill request as seen on the bmem port.
   typedef struct packed {
      logic [31:0] addr;
      logic        read;
   } bmem_req_t;

endpackage

// File: rtl/icache_if.sv
// Instruction cache bus bundle: core fetch port (imem) plus refill port (bmem).
//   slave  : the cache side (takes imem requests, issues bmem refills)
//   master : the environment side (fetch stage + backing memory)
interface icache_if;
   logic [31:0] imem_addr;
   logic [3:0]  imem_rmask;
   logic [31:0] imem_rdata;
   logic        imem_resp;
   logic [31:0] bmem_addr;
   logic        bmem_read;
   logic        bmem_ready;
   logic [63:0] bmem_rdata;
   logic        bmem_rvalid;

   modport slave (
      input  imem_addr, imem_rmask, bmem_ready, bmem_rdata, bmem_rvalid,
      output imem_rdata, imem_resp, bmem_addr, bmem_read
   );

   modport master (
      output imem_addr, imem_rmask, bmem_ready, bmem_rdata, bmem_rvalid,
      input  imem_rdata, imem_resp, bmem_addr, bmem_read
   );
endinterface

// File: rtl/icache_array.sv
// Tag/valid/data storage for the direct-mapped instruction cache.
//   i_rd_en/i_rd_idx         : synchronous read, results registered on o_rd_*
//   i_wr_en/i_wr_idx/...     : line install (tag, data, valid bit)
//   i_clr                    : clear every valid bit at the next edge
module icache_array #(
   parameter int unsigned NUM_SETS   = 16,
   parameter int unsigned IDX_W      = 4,
   parameter int unsigned TAG_W      = 23,
   parameter int unsigned LINE_BITS  = 256,
   parameter bit          RESET_SKIP = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_rd_en,
   input  logic [IDX_W-1:0]     i_rd_idx,
   output logic                 o_rd_valid,
   output logic [TAG_W-1:0]     o_rd_tag,
   output logic [LINE_BITS-1:0] o_rd_data,
   input  logic                 i_wr_en,
   input  logic [IDX_W-1:0]     i_wr_idx,
   input  logic [TAG_W-1:0]     i_wr_tag,
   input  logic [LINE_BITS-1:0] i_wr_data,
   input  logic                 i_wr_valid,
   input  logic                 i_clr
);
   logic [NUM_SETS-1:0]  r_valid;
   logic [TAG_W-1:0]     r_tag  [NUM_SETS];
   logic [LINE_BITS-1:0] r_data [NUM_SETS];
   logic                 r_rd_valid;
   logic [TAG_W-1:0]     r_rd_tag;
   logic [LINE_BITS-1:0] r_rd_data;

   // Valid bits: bulk clear first so a same-edge install still lands its own bit.
   always_ff @(posedge clk) begin
      if (rst && !RESET_SKIP) begin
         r_valid <= '0;
      end else begin
         if (i_clr)
            r_valid <= '0;
         if (i_wr_en)
            r_valid[i_wr_idx] <= i_wr_valid;
      end
   end

   // Tag and data storage (no reset, gated by valid).
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_tag[i_wr_idx]  <= i_wr_tag;
         r_data[i_wr_idx] <= i_wr_data;
      end
   end

   // Registered read; a clear on the read edge makes the lookup see an empty cache.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_valid <= 1'b0;
         r_rd_tag   <= '0;
         r_rd_data  <= '0;
      end else if (i_rd_en) begin
         r_rd_valid <= r_valid[i_rd_idx] && !i_clr;
         r_rd_tag   <= r_tag[i_rd_idx];
         r_rd_data  <= r_data[i_rd_idx];
      end
   end

   assign o_rd_valid = r_rd_valid;
   assign o_rd_tag   = r_rd_tag;
   assign o_rd_data  = r_rd_data;
endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with 64-bit burst refill.
//   clk, rst  : clock, synchronous active-high reset
//   i_inval   : invalidate all lines (fence.i)
//   io_bus    : imem fetch port and bmem refill port (icache_if.slave)
module icache
   import rv32imc_types::*;
#(
   parameter int unsigned NUM_SETS   = 16,
   parameter int unsigned LINE_BYTES = 32,
   parameter bit          RESET_SKIP = 1'b0
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     i_inval,
   icache_if.slave  io_bus
);
   localparam int unsigned BEATS     = LINE_BYTES / 8;
   localparam int unsigned OFF_W     = $clog2(LINE_BYTES);
   localparam int unsigned IDX_W     = $clog2(NUM_SETS);
   localparam int unsigned TAG_W     = 32 - OFF_W - IDX_W;
   localparam int unsigned CNT_W     = $clog2(BEATS);
   localparam int unsigned WSEL_W    = OFF_W - 2;
   localparam int unsigned LINE_BITS = LINE_BYTES * 8;

   icache_state_t        r_state;
   logic [31:2]          r_addr;
   logic [CNT_W-1:0]     r_cnt;
   logic [LINE_BITS-1:0] r_line;
   logic                 r_fill_inval;
   logic                 r_resp;
   logic [31:0]          r_rdata;
   bmem_req_t            r_bmem;

   logic [TAG_W-1:0]     w_tag;
   logic [IDX_W-1:0]     w_idx;
   logic [WSEL_W-1:0]    w_wsel;
   logic                 w_rd_en;
   logic                 w_rd_valid;
   logic [TAG_W-1:0]     w_rd_tag;
   logic [LINE_BITS-1:0] w_rd_data;
   logic                 w_hit;
   logic [31:0]          w_hit_word;
   logic                 w_last;
   logic                 w_wr_en;
   logic                 w_wr_valid;
   logic [LINE_BITS-1:0] w_fill_line;
   logic [31:0]          w_fill_word;

   assign w_tag   = r_addr[31:OFF_W+IDX_W];
   assign w_idx   = r_addr[OFF_W+IDX_W-1:OFF_W];
   assign w_wsel  = r_addr[OFF_W-1:2];
   assign w_rd_en = (r_state == IDLE) && (|io_bus.imem_rmask);

   assign w_hit      = w_rd_valid && (w_rd_tag == w_tag);
   assign w_hit_word = w_rd_data[{w_wsel, 5'b0} +: 32];

   // Line as it will be installed: buffered beats plus the final beat on the bus.
   always_comb begin
      w_fill_line = r_line;
      w_fill_line[LINE_BITS-64 +: 64] = io_bus.bmem_rdata;
   end
   assign w_fill_word = w_fill_line[{w_wsel, 5'b0} +: 32];

   assign w_last     = (r_cnt == CNT_W'(BEATS - 1));
   assign w_wr_en    = !rst && (r_state == FILL) && io_bus.bmem_rvalid && w_last;
   // A fence.i seen at any point of the refill installs the line invalid.
   assign w_wr_valid = !(r_fill_inval || i_inval);

   icache_array #(
      .NUM_SETS   (NUM_SETS),
      .IDX_W      (IDX_W),
      .TAG_W      (TAG_W),
      .LINE_BITS  (LINE_BITS),
      .RESET_SKIP (RESET_SKIP)
   ) u_array (
      .clk        (clk),
      .rst        (rst),
      .i_rd_en    (w_rd_en),
      .i_rd_idx   (io_bus.imem_addr[OFF_W+IDX_W-1:OFF_W]),
      .o_rd_valid (w_rd_valid),
      .o_rd_tag   (w_rd_tag),
      .o_rd_data  (w_rd_data),
      .i_wr_en    (w_wr_en),
      .i_wr_idx   (w_idx),
      .i_wr_tag   (w_tag),
      .i_wr_data  (w_fill_line),
      .i_wr_valid (w_wr_valid),
      .i_clr      (i_inval)
   );

   // Controller FSM with registered imem/bmem outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_addr       <= '0;
         r_cnt        <= '0;
         r_line       <= '0;
         r_fill_inval <= 1'b0;
         r_resp       <= 1'b0;
         r_rdata      <= '0;
         r_bmem       <= '0;
      end else begin
         r_resp <= 1'b0;
         case (r_state)
            IDLE: begin
               if (|io_bus.imem_rmask) begin
                  r_addr  <= io_bus.imem_addr[31:2];
                  r_state <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (w_hit) begin
                  r_resp  <= 1'b1;
                  r_rdata <= w_hit_word;
                  r_state <= IDLE;
               end else begin
                  r_bmem.addr <= {w_tag, w_idx, OFF_W'(0)};
                  r_bmem.read <= 1'b1;
                  r_state     <= REQ;
               end
            end
            REQ: begin
               r_fill_inval <= 1'b0;
               if (io_bus.bmem_ready) begin
                  r_bmem.read <= 1'b0;
                  r_state     <= FILL;
               end
            end
            FILL: begin
               if (i_inval)
                  r_fill_inval <= 1'b1;
               if (io_bus.bmem_rvalid) begin
                  r_line[{r_cnt, 6'b0} +: 64] <= io_bus.bmem_rdata;
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (w_last) begin
                     r_resp  <= 1'b1;
                     r_rdata <= w_fill_word;
                     r_state <= RESP;
                  end
               end
            end
            RESP: begin
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign io_bus.imem_resp  = r_resp;
   assign io_bus.imem_rdata = r_rdata;
   assign io_bus.bmem_addr  = r_bmem.addr;
   assign io_bus.bmem_read  = r_bmem.read;
endmodule
